// File: rtl/extremity_switches_debouncer.sv
// ---------------------------------------------------------------------------
// extremity_switches_debouncer
//   Acquires the two asynchronous extremity-switch contacts and produces the
//   clean rawswitches vector for the LED/switch mapping logic. Each channel:
//   2-FF synchronizer -> debounce FSM -> registered stable level, plus
//   one-cycle edge strobes and a saturating chatter (aborted-transition)
//   counter. No polarity inversion is applied here.
//
// Ports
//   ClkRs_ix        clock/reset bundle (clk, synchronous active-high reset)
//   switches_ia     [1:0] raw asynchronous switch contacts
//   chatter_clear_i clear both chatter counters (wins over an abort)
//   rawswitches_o   [1:0] debounced level per channel
//   valid_o         [1:0] channel has completed initial acquisition
//   rise_o/fall_o   [1:0] one-cycle strobes on accepted 0->1 / 1->0
//   chatter_cnt_oa  [1:0][CHATTER_W-1:0] aborted-transition count per channel
// ---------------------------------------------------------------------------
package ckrs_pkg;
  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;
endpackage

// ---------------------------------------------------------------------------
// extremity_switches_debouncer_ch
//   One debounce channel. Ports: clk, rst (sync active-high), sw_ia (async
//   contact), clr_i (chatter clear), raw_o/valid_o/rise_o/fall_o/chatter_o.
// ---------------------------------------------------------------------------
module extremity_switches_debouncer_ch #(
  parameter int DEBOUNCE_CYCLES = 25000,
  parameter int CHATTER_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_ia,
  input  logic                 clr_i,
  output logic                 raw_o,
  output logic                 valid_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic [CHATTER_W-1:0] chatter_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {INIT, S0, P1, S1, P0} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 raw_q, raw_d;
  logic                 valid_q, valid_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CHATTER_W-1:0] chat_q, chat_d;
  logic                 abort;

  always_comb begin
    sync1_d = sw_ia;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    valid_d = valid_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    abort   = 1'b0;

    unique case (state_q)
      // cnt holds the length of the current run of identical samples; a
      // changed sample is the first of a new run.
      INIT: begin
        if (sync2_q != prev_q) begin
          cnt_d = CW'(1);
        end else if (cnt_q == CNT_LAST) begin
          state_d = sync2_q ? S1 : S0;
          cnt_d   = '0;
          raw_d   = sync2_q;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S0: if (sync2_q) begin
        state_d = P1;
        cnt_d   = CW'(1);
      end
      P1: begin
        if (!sync2_q) begin
          state_d = S0;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S1;
          cnt_d   = '0;
          raw_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S1: if (!sync2_q) begin
        state_d = P0;
        cnt_d   = CW'(1);
      end
      P0: begin
        if (sync2_q) begin
          state_d = S1;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S0;
          cnt_d   = '0;
          raw_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase

    // Clear takes priority over a coincident abort; count saturates.
    if (clr_i)
      chat_d = '0;
    else if (abort && (chat_q != '1))
      chat_d = chat_q + CHATTER_W'(1);
    else
      chat_d = chat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      raw_q   <= 1'b0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      chat_q  <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      chat_q  <= chat_d;
    end
  end

  assign raw_o     = raw_q;
  assign valid_o   = valid_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign chatter_o = chat_q;
endmodule

module extremity_switches_debouncer
  import ckrs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 25000,
  parameter int CHATTER_W       = 8
) (
  input  ckrs_t                         ClkRs_ix,
  input  logic [1:0]                    switches_ia,
  input  logic                          chatter_clear_i,
  output logic [1:0]                    rawswitches_o,
  output logic [1:0]                    valid_o,
  output logic [1:0]                    rise_o,
  output logic [1:0]                    fall_o,
  output logic [1:0][CHATTER_W-1:0]     chatter_cnt_oa
);
  localparam int NUM_CH = 2;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    extremity_switches_debouncer_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CHATTER_W      (CHATTER_W)
    ) u_ch (
      .clk      (ClkRs_ix.clk),
      .rst      (ClkRs_ix.reset),
      .sw_ia    (switches_ia[n]),
      .clr_i    (chatter_clear_i),
      .raw_o    (rawswitches_o[n]),
      .valid_o  (valid_o[n]),
      .rise_o   (rise_o[n]),
      .fall_o   (fall_o[n]),
      .chatter_o(chatter_cnt_oa[n])
    );
  end
endmodule

// File: tb/tb_extremity_switches_debouncer.sv
module tb_extremity_switches_debouncer;
  import ckrs_pkg::*;

  localparam int D    = 8;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [1:0] sw = 2'b00;
  ckrs_t clkrs;
  logic [1:0] raw, vld, rise, fall;
  logic [1:0][CW-1:0] chat;

  assign clkrs = '{clk: clk, reset: rst};
  always #5 clk = ~clk;

  extremity_switches_debouncer #(.DEBOUNCE_CYCLES(D), .CHATTER_W(CW)) dut (
    .ClkRs_ix       (clkrs),
    .switches_ia    (sw),
    .chatter_clear_i(clr),
    .rawswitches_o  (raw),
    .valid_o        (vld),
    .rise_o         (rise),
    .fall_o         (fall),
    .chatter_cnt_oa (chat)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model in terms of sample run lengths: a level is accepted after
  // D consecutive identical synchronized samples (initially) or D consecutive
  // samples differing from the accepted level; a shorter opposite run that
  // ends is an abort.
  logic [1:0] m_s1, m_s2, m_prev, m_acq, m_lvl, m_rise, m_fall;
  int m_run[2], m_opp[2], m_chat[2];

  task automatic model_step();
    for (int n = 0; n < 2; n++) begin
      logic smp;
      logic ab;
      ab = 1'b0;
      if (rst) begin
        m_s1[n] = 0; m_s2[n] = 0; m_prev[n] = 0; m_acq[n] = 0; m_lvl[n] = 0;
        m_rise[n] = 0; m_fall[n] = 0; m_run[n] = 0; m_opp[n] = 0; m_chat[n] = 0;
      end else begin
        smp = m_s2[n];
        m_s2[n] = m_s1[n];
        m_s1[n] = sw[n];
        m_rise[n] = 0;
        m_fall[n] = 0;
        if (!m_acq[n]) begin
          m_run[n] = (smp == m_prev[n]) ? m_run[n] + 1 : 1;
          m_prev[n] = smp;
          if (m_run[n] >= D) begin
            m_acq[n] = 1; m_lvl[n] = smp; m_opp[n] = 0;
          end
        end else if (smp != m_lvl[n]) begin
          m_opp[n]++;
          if (m_opp[n] == D) begin
            m_lvl[n] = smp; m_opp[n] = 0; m_rise[n] = smp; m_fall[n] = !smp;
          end
        end else begin
          ab = (m_opp[n] > 0);
          m_opp[n] = 0;
        end
        if (clr) m_chat[n] = 0;
        else if (ab && m_chat[n] < CMAX) m_chat[n]++;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n clock edges; model follows each edge, DUT compared on negedge.
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model", 32'({raw, vld, rise, fall, chat}),
          32'({m_lvl, m_acq, m_rise, m_fall, 8'(m_chat[1]), 8'(m_chat[0])}));
    end
  endtask

  typedef struct {
    logic rst; logic [1:0] sw; logic clr; int cyc;
    logic [1:0] raw, vld, rise, fall; logic [15:0] chat;
  } vec_t;
  vec_t vt[14];

  initial begin
    //          rst   sw     clr   cyc  raw    vld    rise   fall   chat
    vt[0]  = '{1'b1, 2'b10, 1'b0, 2,  2'b00, 2'b00, 2'b00, 2'b00, 16'h0000};
    vt[1]  = '{1'b0, 2'b10, 1'b0, 9,  2'b00, 2'b01, 2'b00, 2'b00, 16'h0000};
    vt[2]  = '{1'b0, 2'b10, 1'b0, 1,  2'b10, 2'b11, 2'b00, 2'b00, 16'h0000};
    vt[3]  = '{1'b0, 2'b11, 1'b0, 9,  2'b10, 2'b11, 2'b00, 2'b00, 16'h0000};
    vt[4]  = '{1'b0, 2'b11, 1'b0, 1,  2'b11, 2'b11, 2'b01, 2'b00, 16'h0000};
    vt[5]  = '{1'b0, 2'b11, 1'b0, 1,  2'b11, 2'b11, 2'b00, 2'b00, 16'h0000};
    vt[6]  = '{1'b0, 2'b01, 1'b0, 3,  2'b11, 2'b11, 2'b00, 2'b00, 16'h0000};
    vt[7]  = '{1'b0, 2'b11, 1'b0, 4,  2'b11, 2'b11, 2'b00, 2'b00, 16'h0100};
    vt[8]  = '{1'b0, 2'b01, 1'b0, 7,  2'b11, 2'b11, 2'b00, 2'b00, 16'h0100};
    vt[9]  = '{1'b0, 2'b11, 1'b0, 4,  2'b11, 2'b11, 2'b00, 2'b00, 16'h0200};
    vt[10] = '{1'b0, 2'b00, 1'b0, 10, 2'b00, 2'b11, 2'b00, 2'b11, 16'h0200};
    vt[11] = '{1'b0, 2'b00, 1'b0, 1,  2'b00, 2'b11, 2'b00, 2'b00, 16'h0200};
    vt[12] = '{1'b0, 2'b11, 1'b0, 10, 2'b11, 2'b11, 2'b11, 2'b00, 16'h0200};
    vt[13] = '{1'b0, 2'b11, 1'b0, 1,  2'b11, 2'b11, 2'b00, 2'b00, 16'h0200};

    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; sw = vt[i].sw; clr = vt[i].clr;
      tick(vt[i].cyc);
      chk($sformatf("vec%0d raw", i),  32'(raw),  32'(vt[i].raw));
      chk($sformatf("vec%0d vld", i),  32'(vld),  32'(vt[i].vld));
      chk($sformatf("vec%0d rise", i), 32'(rise), 32'(vt[i].rise));
      chk($sformatf("vec%0d fall", i), 32'(fall), 32'(vt[i].fall));
      chk($sformatf("vec%0d chat", i), 32'(chat), 32'(vt[i].chat));
    end

    // 300 one-sample dips on ch0 from S1: each one aborts, counter saturates.
    for (int i = 0; i < 300; i++) begin
      sw = 2'b10; tick(1);
      sw = 2'b11; tick(1);
    end
    tick(3);
    chk("sat chat0", 32'(chat[0]), 32'(CMAX));
    chk("sat raw", 32'(raw), 32'(2'b11));
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clear both", 32'(chat), 32'(0));
    sw = 2'b10; tick(1); sw = 2'b11; tick(3);
    chk("one abort", 32'(chat[0]), 32'(1));
    // Abort lands on the 4th edge after the dip starts; clear on that edge.
    sw = 2'b10; tick(1); sw = 2'b11; tick(2);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clear vs abort", 32'(chat[0]), 32'(0));
    tick(2);
    chk("clear vs abort hold", 32'(chat[0]), 32'(0));

    // Reset while ch0 is pending high with 5 samples counted.
    sw = 2'b00; tick(12);
    sw = 2'b01; tick(7);
    chk("pend raw", 32'(raw), 32'(2'b00));
    rst = 1'b1; tick(1);
    chk("rst raw", 32'(raw), 32'(2'b00));
    chk("rst vld", 32'(vld), 32'(2'b00));
    chk("rst strobe", 32'({rise, fall}), 32'(0));
    rst = 1'b0; tick(9);
    chk("reacq9 vld", 32'(vld), 32'(2'b10));
    chk("reacq9 raw", 32'(raw), 32'(2'b00));
    tick(1);
    chk("reacq10 vld", 32'(vld), 32'(2'b11));
    chk("reacq10 raw", 32'(raw), 32'(2'b01));
    chk("reacq10 rise", 32'(rise), 32'(2'b00));

    // Random segments: glitches around D, long holds, occasional clear/reset.
    for (int s = 0; s < 400; s++) begin
      sw  = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1; tick($urandom_range(1, 3)); rst = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) tick($urandom_range(1, D + 1));
      else tick($urandom_range(D, 2 * D + 4));
    end
    clr = 1'b0;
    tick(2 * D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/extremity_switches_debouncer.md
Name: extremity_switches_debouncer

Overview:
- Acquires the two asynchronous extremity-switch contacts from the front connector and produces the clean `rawswitches` vector consumed by the LED/switch mapping logic.
- Per channel: 2-FF synchronizer, then a debounce state machine, then a registered stable level.
- Also produces one-cycle edge strobes and a saturating chatter counter for diagnostics.
- No polarity inversion here; polarity is handled downstream.

Parameters:
- DEBOUNCE_CYCLES, 25000, consecutive identical synchronized samples required to accept a new level (1 ms at 25 MHz). Legal range >= 2. Counter width is $clog2(DEBOUNCE_CYCLES).
- CHATTER_W, 8, width of each chatter counter.

Ports:
- ClkRs_ix  input  ckrs_t  clock/reset bundle. Single clock ClkRs_ix.clk; ClkRs_ix.reset is synchronous, active-high.
- switches_ia  input  2  raw asynchronous switch contacts.
- chatter_clear_i  input  1  synchronous clear of both chatter counters.
- rawswitches_o  output  2  debounced level per channel.
- valid_o  output  2  channel has completed initial acquisition.
- rise_o  output  2  one-cycle strobe on accepted 0->1.
- fall_o  output  2  one-cycle strobe on accepted 1->0.
- chatter_cnt_oa  output  [1:0][CHATTER_W-1:0]  aborted-transition count per channel.

Behaviour:
- Reset values: all synchronizer FFs 0; state INIT; debounce counter 0; rawswitches_o 0; valid_o 0; rise_o 0; fall_o 0; chatter_cnt_oa 0.
- Reset applies the same on any cycle, including mid-debounce. There is no edge strobe on reset exit.
- Synchronizer: sync = 2nd FF of `switches_ia[n]`. Channels are fully independent and identical.
- States per channel: INIT, S0, P1 (pending high), S1, P0 (pending low).
- INIT:
  - Count consecutive cycles in which sync equals its previous value; restart the count on any change.
  - After DEBOUNCE_CYCLES identical samples, go to S0 or S1 per the sampled level.
  - On that transition: set rawswitches_o to the level, set valid_o=1, no rise/fall strobe.
- S0: if sync=1, go to P1 with counter=1 (that sample counts); else stay.
- P1:
  - sync=0 -> return to S0, counter=0, increment chatter_cnt.
  - sync=1 and counter==DEBOUNCE_CYCLES-1 -> go to S1, rawswitches_o=1, rise_o=1 for exactly one cycle.
  - Otherwise counter++.
- S1/P0: mirror of S0/P1 with levels swapped. An accepted transition sets rawswitches_o=0 and fall_o=1 for one cycle.
- Latency: pin change held stable -> rawswitches_o updates DEBOUNCE_CYCLES+2 clock edges after the first edge that samples the new pin value. rise_o/fall_o are asserted in the same cycle rawswitches_o changes.
- Glitch rejection: any pulse shorter than DEBOUNCE_CYCLES synchronized samples never changes rawswitches_o and produces no strobe.
- Chatter counter:
  - Saturates at 2^CHATTER_W-1 and does not wrap.
  - Increments only on a P1->S0 or P0->S1 abort; INIT restarts do not count.
- chatter_clear_i: sets the counter to 0 next cycle. If clear coincides with an abort, clear wins (result 0).
- No back-pressure: strobes are fire-and-forget.
- valid_o stays 1 until reset.
- All outputs are registered.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=8, CHATTER_W=8.
- Reset release, switches_ia=2'b10 held -> valid_o=2'b11 and rawswitches_o=2'b10 at edge 10 after reset release; rise_o=fall_o=0 throughout.
- From S0, ch0 driven high and held -> rawswitches_o[0]=1 exactly 10 edges after the first sampling edge; rise_o[0]=1 for one cycle; ch1 unaffected.
- From S1, ch1 low pulses of 3 and 7 samples -> rawswitches_o[1] stays 1; no fall_o; chatter_cnt_oa[1]=2.
- 300 aborted pulses on ch0 -> chatter_cnt_oa[0] saturates at 255. Then chatter_clear_i asserted in the same cycle as an abort -> counter reads 0.
- Reset asserted in P1 after 5 high samples -> next cycle state INIT, rawswitches_o=0, valid_o=0, no strobe. Re-acquisition completes after 8 stable samples.
- Both channels toggled on the same edge and held -> rise_o=2'b11 asserted in the same cycle.
